dmem_axi_bridge: RTL
====================

# dmem_axi_bridge

Data-memory bridge downstream of the CPU core's load/store port. Latches one CPU access (address, write data, right-justified byte strobe, read/write), aligns it to 32-bit word lanes, and runs it as a single AXI4-Lite transaction on the data-memory bus. It returns right-justified read data with a one-cycle completion pulse. Misaligned or erroring accesses are flagged; sign extension stays in the core.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_rw  in  1  1 = write, 0 = read.
- cpu_wstrobe  in  4  right-justified size mask. Legal values: 4'b0001 (byte), 4'b0011 (half), 4'b1111 (word).
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  right-justified store data.
- cpu_busy  out  1  high from acceptance through the done cycle.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done: misaligned access or non-OKAY response.
- cpu_rdata  out  32  right-justified load data; upper unused bytes are 0; held until the next acceptance.
- m_awaddr  out  ADDR_W
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  32
- m_wstrb  out  4
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1
- m_araddr  out  ADDR_W
- m_arvalid  out  1
- m_arready  in  1
- m_rdata  in  32
- m_rresp  in  2
- m_rvalid  in  1
- m_rready  out  1

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA, DONE.
- IDLE with cpu_req=1 latches all request fields and sets cpu_busy.
  - Misaligned access goes to DONE with err=1 and issues no bus traffic.
  - Otherwise a write goes to WRITE and a read goes to RADDR.
- Misaligned definition: half with addr[0]=1, or word with addr[1:0]≠0. An illegal cpu_wstrobe value is also treated as misaligned.
- Lane alignment, with off = addr[1:0]:
  - m_wstrb = wstrobe << off.
  - m_wdata = wdata << 8·off.
  - m_awaddr and m_araddr = {addr[ADDR_W-1:2], 2'b00}.
- WRITE:
  - m_awvalid and m_wvalid are asserted together.
  - Each valid drops independently after its own handshake; per-channel done bits are kept.
  - Move to WRESP once both handshakes are done, including both in the same cycle.
- WRESP: m_bready=1. On m_bvalid, set err = (m_bresp≠0) and go to DONE.
- RADDR: m_arvalid=1 until m_arready, then go to RDATA.
- RDATA: m_rready=1. On m_rvalid:
  - cpu_rdata = (m_rdata >> 8·off) masked by the size (byte → [7:0], half → [15:0]).
  - err = (m_rresp≠0); go to DONE.
  - Read data is still written on error.
- DONE: cpu_done=1 for one cycle, cpu_busy=1, then back to IDLE. cpu_req in DONE is ignored.
- cpu_req while busy is ignored; it is never queued.
- A valid, once raised, stays high with its payload stable until its handshake.

## Timing
- Reset values:
  - State IDLE.
  - All m_*valid, m_bready, m_rready, cpu_busy, cpu_done, cpu_err = 0.
  - cpu_rdata, m_awaddr, m_araddr, m_wdata, m_wstrb = 0.
- Reset mid-transaction: next edge forces IDLE and drops all valids. The slave is reset on the same nreset.
- All outputs are registered.
- Best-case write (all readies high, bvalid the cycle after W): req at cycle 0, aw/w handshake cycle 1, b handshake cycle 2, cpu_done cycle 3.
- Best-case read: ar cycle 1, r cycle 2, cpu_done cycle 3.
- Misaligned access: cpu_done at cycle 1.
- Minimum issue interval: 4 cycles, because the next request can only be accepted in IDLE.

## Test plan
- SW: addr 0x80000010, wdata 0xDEADBEEF, wstrobe 1111, slave always ready → awaddr 0x80000010, wstrb 1111, wdata 0xDEADBEEF; done at cycle 3, err=0.
- SB: addr 0x80000013, wdata 0x000000A5 → wstrb 1000, wdata 0xA5000000, awaddr 0x80000010.
- LH: addr 0x80000022, slave rdata 0x1234ABCD → cpu_rdata 0x00001234. LBU at addr 0x80000021 → 0x000000AB.
- Backpressure: awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles with stable payload; single B; exactly one done.
- Errors:
  - LW at addr 0x80000002 → no valid ever rises; done at cycle 1 with err=1.
  - Read with rresp=2'b10 → done with err=1.
- Reset and busy handling:
  - nreset low while in WRESP → next cycle IDLE, all outputs at reset values.
  - cpu_req held high through a transaction → exactly one transaction, then re-acceptance only in IDLE.

Source files
------------

// File: rtl/dmem_axi_bridge.sv
// Bridges one CPU load/store at a time onto an AXI4-Lite data-memory bus.
// Store data and strobes are shifted into their word lanes; load data is shifted back and masked to the access size.
module dmem_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [3:0]        cpu_wstrobe,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic [3:0]          size_q, size_d;
    logic [1:0]          off_q, off_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                misaligned;
    logic                awDone, wDone;
    logic [31:0]         sizeMask;

    // Illegal size codes are folded into the misaligned error path.
    always_comb begin
        misaligned = 1'b1;
        case (cpu_wstrobe)
            4'b0001: misaligned = 1'b0;
            4'b0011: misaligned = cpu_addr[0];
            4'b1111: misaligned = |cpu_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        sizeMask = 32'hFFFF_FFFF;
        case (size_q)
            4'b0001: sizeMask = 32'h0000_00FF;
            4'b0011: sizeMask = 32'h0000_FFFF;
            default: sizeMask = 32'hFFFF_FFFF;
        endcase
    end

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign awDone = !awvalid_q || m_awready;
    assign wDone  = !wvalid_q  || m_wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        size_d    = size_q;
        off_d     = off_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    wdata_d = cpu_wdata << {cpu_addr[1:0], 3'b000};
                    wstrb_d = cpu_wstrobe << cpu_addr[1:0];
                    size_d  = cpu_wstrobe;
                    off_d   = cpu_addr[1:0];
                    if (misaligned) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (cpu_rw) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WRITE: begin
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if (awDone && wDone) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = |m_bresp;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            RADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = (m_rdata >> {off_q, 3'b000}) & sizeMask;
                    err_d    = |m_rresp;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            size_q    <= size_d;
            off_q     <= off_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign cpu_rdata = rdata_q;
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule
